// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between the decode stage, the ALU control sequencer
// and the execute-side consumer. The master drives requests and consumes results.
interface alu_ctrl_seq_if;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] alu_op;
    logic       opcode_5;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_ctrl;
    logic       out_illegal;
    logic       busy;

    modport master (
        output flush,
        output in_valid,
        output alu_op,
        output opcode_5,
        output funct3,
        output funct7,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ctrl,
        input  out_illegal,
        input  busy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  alu_op,
        input  opcode_5,
        input  funct3,
        input  funct7,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ctrl,
        output out_illegal,
        output busy
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder for RV32I/RV32M at the ID/EX boundary. Each
// accepted op is held for its class latency before out_valid is raised.
module alu_ctrl_seq #(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAT_MUL_M1 = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_DIV_M1 = CNT_W'(DIV_CYCLES - 1);

    localparam logic [4:0] CTRL_ADD   = 5'd0;
    localparam logic [4:0] CTRL_SUB   = 5'd1;
    localparam logic [4:0] CTRL_AND   = 5'd2;
    localparam logic [4:0] CTRL_OR    = 5'd3;
    localparam logic [4:0] CTRL_XOR   = 5'd4;
    localparam logic [4:0] CTRL_SLT   = 5'd5;
    localparam logic [4:0] CTRL_SLTU  = 5'd6;
    localparam logic [4:0] CTRL_SLL   = 5'd7;
    localparam logic [4:0] CTRL_SRL   = 5'd8;
    localparam logic [4:0] CTRL_SRA   = 5'd9;
    localparam logic [4:0] CTRL_MUL   = 5'd10;
    localparam logic [4:0] CTRL_MULHU = 5'd13;
    localparam logic [4:0] CTRL_DIV   = 5'd14;
    localparam logic [4:0] CTRL_REMU  = 5'd17;
    localparam logic [4:0] CTRL_PASSB = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [4:0]       r_out_ctrl;
    logic             r_out_illegal;
    logic             r_busy;

    logic             w_in_ready;
    logic             w_accept;
    logic [4:0]       w_ctrl;
    logic             w_illegal;
    logic             w_shift;
    logic             w_f7_chk;
    logic             w_f7_ok;
    logic [CNT_W-1:0] w_lat_m1;

    // funct7[5] selects sub only on R-type; it selects sra for both shift forms
    function automatic logic [4:0] base_ctrl(input logic [2:0] f3,
                                             input logic       f7_5,
                                             input logic       op5);
        logic [4:0] c;
        case (f3)
            3'b000:  c = (op5 && f7_5) ? CTRL_SUB : CTRL_ADD;
            3'b001:  c = CTRL_SLL;
            3'b010:  c = CTRL_SLT;
            3'b011:  c = CTRL_SLTU;
            3'b100:  c = CTRL_XOR;
            3'b101:  c = f7_5 ? CTRL_SRA : CTRL_SRL;
            3'b110:  c = CTRL_OR;
            3'b111:  c = CTRL_AND;
            default: c = CTRL_ADD;
        endcase
        return c;
    endfunction

    // Field decode into control word and legality
    always_comb begin
        w_ctrl    = CTRL_ADD;
        w_illegal = 1'b0;
        w_shift   = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
        w_f7_chk  = bus.opcode_5 || w_shift;
        w_f7_ok   = (bus.funct7 == 7'b0000000) ||
                    ((bus.funct7 == 7'b0100000) &&
                     ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)));
        case (bus.alu_op)
            3'b000: w_ctrl = CTRL_ADD;
            3'b001: w_ctrl = CTRL_SUB;
            3'b011: w_ctrl = CTRL_PASSB;
            3'b010: begin
                if (bus.opcode_5 && (bus.funct7 == 7'b0000001)) begin
                    if (ENABLE_M != 0) begin
                        w_ctrl = CTRL_MUL + {2'b00, bus.funct3};
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else if (w_f7_chk && !w_f7_ok) begin
                    w_illegal = 1'b1;
                end else begin
                    w_ctrl = base_ctrl(bus.funct3, bus.funct7[5], bus.opcode_5);
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Remaining cycles after the accept edge, by op class
    always_comb begin
        w_lat_m1 = '0;
        if ((w_ctrl >= CTRL_DIV) && (w_ctrl <= CTRL_REMU)) begin
            w_lat_m1 = LAT_DIV_M1;
        end else if ((w_ctrl >= CTRL_MUL) && (w_ctrl <= CTRL_MULHU)) begin
            w_lat_m1 = LAT_MUL_M1;
        end else begin
            w_lat_m1 = '0;
        end
    end

    assign w_in_ready = !bus.flush &&
                        ((r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;

    // Handshake FSM; flush outranks accept, DONE may reload without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_out_ctrl    <= 5'd0;
            r_out_illegal <= 1'b0;
            r_busy        <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_out_ctrl    <= w_ctrl;
            r_out_illegal <= w_illegal;
            r_cnt         <= w_lat_m1;
            r_busy        <= 1'b1;
            if (w_lat_m1 == '0) begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
            end else begin
                r_state     <= ST_BUSY;
                r_out_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
                ST_BUSY: begin
                    if (r_cnt <= CNT_ONE) begin
                        r_state     <= ST_DONE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_ctrl    = r_out_ctrl;
    assign bus.out_illegal = r_out_illegal;
    assign bus.busy        = r_busy;
endmodule
